// File: rtl/lmmi_init_pkg.sv
// Shared types and constants for the LMMI boot-time init sequencer and its ROM.
package lmmi_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WR,
    ST_RD,
    ST_RWAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_VERIFY  = 3'd2;
  localparam logic [2:0] ERR_TGT     = 3'd3;
  localparam logic [2:0] ERR_LOCK    = 3'd4;

  localparam int unsigned LMMI_OFFSET_W = 5;
  localparam int unsigned LMMI_DATA_W   = 8;
  localparam int unsigned LMMI_IDX_W    = 5;
  localparam int unsigned TGT_W         = 2;
  localparam int unsigned ENTRY_W       = 2 + TGT_W + LMMI_OFFSET_W + LMMI_DATA_W;

  // Entry layout from MSB: last, verify, tgt, offset, data
  localparam int unsigned DATA_LSB   = 0;
  localparam int unsigned OFFSET_LSB = DATA_LSB + LMMI_DATA_W;
  localparam int unsigned TGT_LSB    = OFFSET_LSB + LMMI_OFFSET_W;
  localparam int unsigned VERIFY_BIT = TGT_LSB + TGT_W;
  localparam int unsigned LAST_BIT   = VERIFY_BIT + 1;

  localparam logic [1:0] TGT_DPHY_RX = 2'd0;
  localparam logic [1:0] TGT_DPHY_TX = 2'd1;
  localparam logic [1:0] TGT_I2C1    = 2'd2;
  localparam logic [1:0] TGT_I2C2    = 2'd3;

  typedef struct packed {
    logic                     last;
    logic                     verify;
    logic [TGT_W-1:0]         tgt;
    logic [LMMI_OFFSET_W-1:0] offset;
    logic [LMMI_DATA_W-1:0]   data;
  } entry_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic last, input logic verify,
                                                  input logic [TGT_W-1:0] tgt,
                                                  input logic [LMMI_OFFSET_W-1:0] offset,
                                                  input logic [LMMI_DATA_W-1:0] data);
    entry_t e;
    e.last   = last;
    e.verify = verify;
    e.tgt    = tgt;
    e.offset = offset;
    e.data   = data;
    return e;
  endfunction

endpackage

// File: rtl/lmmi_init_rom.sv
// Board init table: registered case ROM, one-cycle read latency.
module lmmi_init_rom
  import lmmi_init_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LMMI_IDX_W-1:0] addr,
  output logic [ENTRY_W-1:0]    data
);

  logic [ENTRY_W-1:0] entry_c;

  // D-PHY lane/clock setup first, then I2C prescalers; 4-bit I2C regs use the low data bits
  always_comb begin
    entry_c = '0;
    case (addr)
      LMMI_IDX_W'(0): entry_c = mk_entry(1'b0, 1'b0, TGT_DPHY_RX, 5'h00, 8'h01);
      LMMI_IDX_W'(1): entry_c = mk_entry(1'b0, 1'b0, TGT_DPHY_RX, 5'h01, 8'h1F);
      LMMI_IDX_W'(2): entry_c = mk_entry(1'b0, 1'b0, TGT_DPHY_TX, 5'h00, 8'h01);
      LMMI_IDX_W'(3): entry_c = mk_entry(1'b0, 1'b1, TGT_DPHY_TX, 5'h04, 8'h2A);
      LMMI_IDX_W'(4): entry_c = mk_entry(1'b0, 1'b1, TGT_I2C1,    5'h03, 8'h0A);
      LMMI_IDX_W'(5): entry_c = mk_entry(1'b1, 1'b0, TGT_I2C2,    5'h03, 8'h05);
      default:        entry_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= entry_c;
  end

endmodule

// File: rtl/lmmi_init_seq.sv
// Boot-time LMMI configuration sequencer: walks the init ROM after PLL lock and
// issues one (optionally read-back verified) LMMI write per entry.
module lmmi_init_seq
  import lmmi_init_pkg::*;
#(
  parameter int unsigned NUM_TGT  = 4,
  parameter int unsigned OFFSET_W = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 pll_lock_i,
  input  logic                                 start_i,
  output logic [IDX_W-1:0]                     rom_addr_o,
  input  logic [2+TGT_W+OFFSET_W+DATA_W-1:0]   rom_data_i,
  output logic [NUM_TGT-1:0]                   lmmi_request_o,
  output logic                                 lmmi_wr_rdn_o,
  output logic [OFFSET_W-1:0]                  lmmi_offset_o,
  output logic [DATA_W-1:0]                    lmmi_wdata_o,
  input  logic [NUM_TGT-1:0]                   lmmi_ready_i,
  input  logic [NUM_TGT*DATA_W-1:0]            lmmi_rdata_i,
  input  logic [NUM_TGT-1:0]                   lmmi_rdata_valid_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 error_o,
  output logic [2:0]                           err_code_o,
  output logic [IDX_W-1:0]                     err_idx_o
);

  localparam int unsigned SLOTS  = 2 ** TGT_W;
  localparam int unsigned RD_W   = SLOTS * DATA_W;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned F_OFF  = DATA_W;
  localparam int unsigned F_TGT  = F_OFF + OFFSET_W;
  localparam int unsigned F_VER  = F_TGT + TGT_W;
  localparam int unsigned F_LAST = F_VER + 1;

  function automatic logic [SLOTS-1:0] tgt_ok_mask();
    logic [SLOTS-1:0] m;
    for (int unsigned i = 0; i < SLOTS; i++) m[i] = (i < NUM_TGT);
    return m;
  endfunction

  localparam logic [SLOTS-1:0] TGT_OK = tgt_ok_mask();

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [TGT_W-1:0]    tgt, tgt_nxt;
  logic                ver, ver_nxt;
  logic                last, last_nxt;
  logic [SLOTS-1:0]    req, req_nxt;
  logic                wr_rdn, wr_nxt;
  logic [OFFSET_W-1:0] offset, off_nxt;
  logic [DATA_W-1:0]   wdata, wd_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                busy, busy_nxt;
  logic                done, error;
  logic [2:0]          code, code_nxt;
  logic [IDX_W-1:0]    eidx, eidx_nxt;

  logic [SLOTS-1:0]    ready_x, rvalid_x;
  logic [RD_W-1:0]     rdata_x;
  logic [TGT_W-1:0]    rom_tgt;
  logic                accepted, timeout, abort, adv;
  logic [2:0]          abort_code;

  // Pad per-target buses to the full tgt field range so any tgt value indexes safely
  assign ready_x  = SLOTS'(lmmi_ready_i);
  assign rvalid_x = SLOTS'(lmmi_rdata_valid_i);
  assign rdata_x  = RD_W'(lmmi_rdata_i);
  assign rom_tgt  = rom_data_i[F_TGT +: TGT_W];
  assign accepted = |(req & ready_x);
  assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tgt_nxt    = tgt;
    ver_nxt    = ver;
    last_nxt   = last;
    req_nxt    = req;
    wr_nxt     = wr_rdn;
    off_nxt    = offset;
    wd_nxt     = wdata;
    cnt_nxt    = cnt;
    code_nxt   = code;
    eidx_nxt   = eidx;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    adv        = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i && pll_lock_i) begin
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
          code_nxt  = ERR_NONE;
          eidx_nxt  = '0;
        end
      end
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        tgt_nxt  = rom_tgt;
        ver_nxt  = rom_data_i[F_VER];
        last_nxt = rom_data_i[F_LAST];
        if (!TGT_OK[rom_tgt]) begin
          abort      = 1'b1;
          abort_code = ERR_TGT;
        end else begin
          state_nxt = ST_WR;
          req_nxt   = SLOTS'(1) << rom_tgt;
          wr_nxt    = 1'b1;
          off_nxt   = rom_data_i[F_OFF +: OFFSET_W];
          wd_nxt    = rom_data_i[0 +: DATA_W];
          cnt_nxt   = '0;
        end
      end
      ST_WR: begin
        if (accepted) begin
          if (ver) begin
            state_nxt = ST_RD;
            wr_nxt    = 1'b0;
            cnt_nxt   = '0;
          end else begin
            adv = 1'b1;
          end
        end else if (timeout) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RD: begin
        if (accepted) begin
          state_nxt = ST_RWAIT;
          req_nxt   = '0;
          cnt_nxt   = '0;
        end else if (timeout) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RWAIT: begin
        if (rvalid_x[tgt]) begin
          if (rdata_x[tgt*DATA_W +: DATA_W] == wdata) begin
            adv = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_VERIFY;
          end
        end else if (timeout) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Lock loss overrides any ready/valid/timeout outcome in the same cycle
    if ((state inside {ST_FETCH, ST_DECODE, ST_WR, ST_RD, ST_RWAIT}) && !pll_lock_i) begin
      abort      = 1'b1;
      abort_code = ERR_LOCK;
      adv        = 1'b0;
    end

    if (adv) begin
      req_nxt = '0;
      if (last || (idx == '1)) begin
        state_nxt = ST_DONE;
      end else begin
        idx_nxt   = idx + IDX_W'(1);
        state_nxt = ST_FETCH;
      end
    end

    if (abort) begin
      state_nxt = ST_ERR;
      req_nxt   = '0;
      code_nxt  = abort_code;
      eidx_nxt  = idx;
    end

    busy_nxt = state_nxt inside {ST_FETCH, ST_DECODE, ST_WR, ST_RD, ST_RWAIT};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      idx    <= '0;
      tgt    <= '0;
      ver    <= 1'b0;
      last   <= 1'b0;
      req    <= '0;
      wr_rdn <= 1'b0;
      offset <= '0;
      wdata  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      code   <= ERR_NONE;
      eidx   <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      tgt    <= tgt_nxt;
      ver    <= ver_nxt;
      last   <= last_nxt;
      req    <= req_nxt;
      wr_rdn <= wr_nxt;
      offset <= off_nxt;
      wdata  <= wd_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= (state_nxt == ST_DONE);
      error  <= (state_nxt == ST_ERR);
      code   <= code_nxt;
      eidx   <= eidx_nxt;
    end
  end

  assign rom_addr_o     = idx;
  assign lmmi_request_o = NUM_TGT'(req);
  assign lmmi_wr_rdn_o  = wr_rdn;
  assign lmmi_offset_o  = offset;
  assign lmmi_wdata_o   = wdata;
  assign busy_o         = busy;
  assign done_o         = done;
  assign error_o        = error;
  assign err_code_o     = code;
  assign err_idx_o      = eidx;

endmodule

// File: tb/tb_lmmi_init_seq.sv
// Directed bench for lmmi_init_seq (three targets) plus a spot check of the board ROM.
module tb_lmmi_init_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic        start;
  logic [2:0]  rdy;
  logic [4:0]  rom_addr;
  logic [16:0] rom_data;
  logic [16:0] rom_mem [32];
  logic [2:0]  req;
  logic        wr_rdn;
  logic [4:0]  offset;
  logic [7:0]  wdata;
  logic [2:0]  rv = '0;
  logic [2:0]  pend = '0;
  logic [23:0] rdata;
  logic [7:0]  rd_val;
  int          rd_lat;
  int          cd = 0;
  logic        busy, done, error;
  logic [2:0]  code;
  logic [4:0]  eidx;
  logic [4:0]  rc_addr;
  logic [16:0] rc_data;
  logic        wr_clr;
  int          n_wr = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  lmmi_init_seq #(.NUM_TGT(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pll_lock_i(lock), .start_i(start),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .lmmi_request_o(req), .lmmi_wr_rdn_o(wr_rdn), .lmmi_offset_o(offset),
    .lmmi_wdata_o(wdata), .lmmi_ready_i(rdy), .lmmi_rdata_i(rdata),
    .lmmi_rdata_valid_i(rv), .busy_o(busy), .done_o(done), .error_o(error),
    .err_code_o(code), .err_idx_o(eidx)
  );

  lmmi_init_rom u_rom (.clk(clk), .rst_n(rst_n), .addr(rc_addr), .data(rc_data));

  assign rdata = {3{rd_val}};

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Target model: read data valid rd_lat cycles after a read is accepted
  always @(posedge clk) begin
    rv <= '0;
    if (|(req & rdy) && !wr_rdn) begin
      cd   <= rd_lat;
      pend <= req;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) rv <= pend;
    end
  end

  always @(posedge clk) begin
    if (wr_clr) n_wr <= 0;
    else if (|(req & rdy) && wr_rdn) n_wr <= n_wr + 1;
  end

  function automatic logic [16:0] ent(input logic l, input logic v, input logic [1:0] t,
                                      input logic [4:0] o, input logic [7:0] d);
    return {l, v, t, o, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 32; i++) rom_mem[i] = '0;
  endtask

  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int max, input string tag);
    int k;
    k = 0;
    while (!(done || error) && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(done | error), 1);
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b1; start = 1'b0; rdy = 3'b111;
    rd_lat = 2; rd_val = 8'hA5; rc_addr = '0; wr_clr = 1'b1;
    rom_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_clr = 1'b0;
    tick();

    // Reset state
    chk("rst_req", 32'(req), 0);
    chk("rst_wr_rdn", 32'(wr_rdn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_eidx", 32'(eidx), 0);
    chk("rst_addr", 32'(rom_addr), 0);

    // Board ROM spot check
    rc_addr = 5'd3; tick();
    chk("rom_e3", 32'(rc_data), 'hA42A);
    rc_addr = 5'd5; tick();
    chk("rom_e5", 32'(rc_data), 'h16305);

    // Three write entries, ready tied high
    rom_mem[0] = ent(1'b0, 1'b0, 2'd0, 5'h01, 8'h11);
    rom_mem[1] = ent(1'b0, 1'b0, 2'd1, 5'h02, 8'h22);
    rom_mem[2] = ent(1'b1, 1'b0, 2'd2, 5'h03, 8'h33);
    start_seq();
    chk("a_busy_fetch", 32'(busy), 1);
    tick();
    chk("a_req_e2", 32'(req), 0);
    tick();
    chk("a_req_e3", 32'(req), 'b001);
    chk("a_off_e3", 32'(offset), 'h01);
    chk("a_wd_e3", 32'(wdata), 'h11);
    chk("a_wr_e3", 32'(wr_rdn), 1);
    tick();
    chk("a_req_e4", 32'(req), 0);
    repeat (2) tick();
    chk("a_req_e6", 32'(req), 'b010);
    chk("a_off_e6", 32'(offset), 'h02);
    repeat (3) tick();
    chk("a_req_e9", 32'(req), 'b100);
    chk("a_wd_e9", 32'(wdata), 'h33);
    tick();
    chk("a_done", 32'(done), 1);
    chk("a_busy_end", 32'(busy), 0);
    chk("a_req_end", 32'(req), 0);
    chk("a_error", 32'(error), 0);

    // Verified entry, read-back matches
    rom_clear();
    rom_mem[0] = ent(1'b1, 1'b1, 2'd2, 5'h03, 8'hA5);
    rd_val = 8'hA5;
    start_seq();
    chk("b_done_clr", 32'(done), 0);
    repeat (2) tick();
    chk("b_wr_req", 32'(req), 'b100);
    chk("b_wr_rdn", 32'(wr_rdn), 1);
    tick();
    chk("b_rd_req", 32'(req), 'b100);
    chk("b_rd_rdn", 32'(wr_rdn), 0);
    wait_end(40, "b_wait");
    chk("b_done", 32'(done), 1);
    chk("b_code", 32'(code), 0);

    // Verified entry, read-back mismatches
    rd_val = 8'hA4;
    start_seq();
    wait_end(40, "b2_wait");
    chk("b2_error", 32'(error), 1);
    chk("b2_code", 32'(code), 2);
    chk("b2_eidx", 32'(eidx), 0);
    chk("b2_done", 32'(done), 0);
    chk("b2_req", 32'(req), 0);

    // Start without lock is ignored
    lock = 1'b0;
    start_seq();
    tick();
    chk("nl_error", 32'(error), 1);
    chk("nl_busy", 32'(busy), 0);
    lock = 1'b1;

    // Target never ready: timeout
    rom_clear();
    rom_mem[0] = ent(1'b1, 1'b0, 2'd1, 5'h07, 8'h5A);
    rdy = 3'b000;
    start_seq();
    repeat (2) tick();
    chk("c_req_first", 32'(req), 'b010);
    repeat (254) tick();
    chk("c_req_last", 32'(req), 'b010);
    chk("c_err_early", 32'(error), 0);
    tick();
    chk("c_req_drop", 32'(req), 0);
    chk("c_error", 32'(error), 1);
    chk("c_code", 32'(code), 1);
    chk("c_eidx", 32'(eidx), 0);
    rdy = 3'b111;

    // Bad target on entry 1
    rom_clear();
    rom_mem[0] = ent(1'b0, 1'b0, 2'd0, 5'h01, 8'h01);
    rom_mem[1] = ent(1'b0, 1'b0, 2'd3, 5'h02, 8'h02);
    start_seq();
    repeat (4) tick();
    chk("d_req_dec", 32'(req), 0);
    tick();
    chk("d_req", 32'(req), 0);
    chk("d_error", 32'(error), 1);
    chk("d_code", 32'(code), 3);
    chk("d_eidx", 32'(eidx), 1);

    // Lock lost while entry 4 is in WR
    rom_clear();
    for (int i = 0; i < 6; i++) rom_mem[i] = ent(1'b0, 1'b0, 2'(i % 3), 5'(i), 8'(8'h40 + i));
    start_seq();
    repeat (14) tick();
    chk("e_req_wr4", 32'(req), 'b010);
    chk("e_addr_wr4", 32'(rom_addr), 4);
    lock = 1'b0;
    tick();
    chk("e_req", 32'(req), 0);
    chk("e_error", 32'(error), 1);
    chk("e_code", 32'(code), 4);
    chk("e_eidx", 32'(eidx), 4);
    chk("e_busy", 32'(busy), 0);
    lock = 1'b1;

    // Full ROM with no last bit; start while busy is ignored
    rom_clear();
    for (int i = 0; i < 32; i++) rom_mem[i] = ent(1'b0, 1'b0, 2'd0, 5'(i), 8'(i));
    wr_clr = 1'b1;
    tick();
    wr_clr = 1'b0;
    start_seq();
    repeat (30) tick();
    chk("f_busy_mid", 32'(busy), 1);
    chk("f_addr_mid", 32'(rom_addr), 10);
    start_seq();
    chk("f_addr_after_start", 32'(rom_addr), 10);
    chk("f_busy_after_start", 32'(busy), 1);
    wait_end(200, "f_wait");
    chk("f_nwr", 32'(n_wr), 32);
    chk("f_done", 32'(done), 1);
    chk("f_error", 32'(error), 0);
    chk("f_addr_end", 32'(rom_addr), 31);
    repeat (5) tick();
    chk("f_addr_hold", 32'(rom_addr), 31);
    chk("f_nwr_hold", 32'(n_wr), 32);
    chk("f_busy_hold", 32'(busy), 0);

    // Reset asserted mid-transfer
    rom_clear();
    rom_mem[0] = ent(1'b1, 1'b0, 2'd0, 5'h1F, 8'hFF);
    rdy = 3'b000;
    start_seq();
    repeat (2) tick();
    chk("g_req_wr", 32'(req), 'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("g_req_async", 32'(req), 0);
    chk("g_busy_async", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    rdy = 3'b111;
    repeat (5) tick();
    chk("g_req_after", 32'(req), 0);
    chk("g_busy_after", 32'(busy), 0);
    chk("g_done_after", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
